program_loader_verilog: RTL and testbench

- Writer side of the program memory that the processor fetches opcode/operand pairs from.
- Accepts a byte stream over a valid/ready handshake and assembles it into 16-bit opcode/operand instruction words.
- Writes each word to sequential program memory addresses, checks a trailing XOR checksum, then releases the processor from hold.

---
 rtl/program_loader_verilog_if.sv | 21 ++
 rtl/program_loader_verilog.sv | 130 +++++++++++++
 tb/tb_program_loader_verilog.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_verilog_if.sv
// program_loader_verilog_if: byte-stream input and program-memory write port of the loader.
interface program_loader_verilog_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_opcode;
    logic [DATA_WIDTH-1:0] prog_operand;
    modport master (
        output in_data, in_valid,
        input  in_ready, prog_we, prog_addr, prog_opcode, prog_operand
    );
    modport slave (
        input  in_data, in_valid,
        output in_ready, prog_we, prog_addr, prog_opcode, prog_operand
    );
endinterface

// File: rtl/program_loader_verilog.sv
// program_loader_verilog: assembles a length-prefixed, XOR-checked byte stream into
// opcode/operand words, writes them to program memory and releases the CPU on success.
module program_loader_verilog #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    program_loader_verilog_if.slave bus,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_WIDTH:0]     loaded_count
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, BODY, CHECK, DONE, ERROR} state_t;
    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);

    state_t                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d, chk_q, chk_d;
    logic [1:0]            phase_q, phase_d;
    logic [23:0]           buf_q, buf_d;
    logic [ADDR_WIDTH:0]   len_q, len_d, count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] op_q, op_d, opd_q, opd_d;
    logic                  we_q, we_d, ready_q, ready_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
    logic                  accept;
    logic [15:0]           len_word;

    assign accept   = bus.in_valid && ready_q;
    assign len_word = {len_hi_q, bus.in_data};

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        chk_d    = chk_q;
        phase_d  = phase_q;
        buf_d    = buf_q;
        len_d    = len_q;
        count_d  = count_q;
        addr_d   = addr_q;
        op_d     = op_q;
        opd_d    = opd_q;
        we_d     = 1'b0;
        // the checksum byte itself is not folded into the running XOR
        if (accept && state_q != CHECK)
            chk_d = chk_q ^ bus.in_data;
        case (state_q)
            IDLE, DONE, ERROR: if (start) begin
                state_d = LEN_HI;
                count_d = '0;
                chk_d   = '0;
                phase_d = '0;
            end
            LEN_HI: if (accept) begin
                len_hi_d = bus.in_data;
                state_d  = LEN_LO;
            end
            LEN_LO: if (accept) begin
                len_d   = len_word[ADDR_WIDTH:0];
                state_d = {1'b0, len_word} > MAX_LEN ? ERROR : len_word == 16'd0 ? CHECK : BODY;
            end
            BODY: if (accept) begin
                phase_d = phase_q + 2'd1;
                buf_d   = {buf_q[15:0], bus.in_data};
                if (phase_q == 2'd3) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_WIDTH-1:0];
                    op_d    = buf_q[23:8];
                    opd_d   = {buf_q[7:0], bus.in_data};
                    count_d = count_q + 1'b1;
                    state_d = count_d == len_q ? CHECK : BODY;
                end
            end
            CHECK: if (accept)
                state_d = bus.in_data == chk_q ? DONE : ERROR;
            default: ;
        endcase
        ready_d = state_d inside {LEN_HI, LEN_LO, BODY, CHECK};
        hold_d  = state_d != DONE;
        done_d  = state_d == DONE;
        err_d   = state_d == ERROR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            len_hi_q <= '0;
            chk_q    <= '0;
            phase_q  <= '0;
            buf_q    <= '0;
            len_q    <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            op_q     <= '0;
            opd_q    <= '0;
            we_q     <= 1'b0;
            ready_q  <= 1'b0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            chk_q    <= chk_d;
            phase_q  <= phase_d;
            buf_q    <= buf_d;
            len_q    <= len_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            op_q     <= op_d;
            opd_q    <= opd_d;
            we_q     <= we_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready     = ready_q;
    assign bus.prog_we      = we_q;
    assign bus.prog_addr    = addr_q;
    assign bus.prog_opcode  = op_q;
    assign bus.prog_operand = opd_q;
    assign cpu_hold         = hold_q;
    assign done             = done_q;
    assign error            = err_q;
    assign loaded_count     = count_q;
endmodule

// File: tb/tb_program_loader_verilog.sv
// tb_program_loader_verilog: random and directed loads checked against a stream-level
// model of the expected memory writes and final status.
module tb_program_loader_verilog;
    localparam int AW = 8;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic cpu_hold, done, error;
    logic [AW:0] loaded_count;

    program_loader_verilog_if #(.DATA_WIDTH(16), .ADDR_WIDTH(AW)) bus();
    program_loader_verilog #(.DATA_WIDTH(16), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .done(done), .error(error), .loaded_count(loaded_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   op;
        logic [15:0]   opd;
    } wr_t;

    int checks = 0, errors = 0;
    wr_t exp_q[$], log_q[$];
    wr_t cw, dw;
    logic [7:0] stream[$];
    logic exp_done, exp_err;
    int exp_cnt;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected writes and outcome derived directly from the stream format.
    function automatic void model();
        int n;
        logic [7:0] x;
        n = {stream[0], stream[1]};
        if (n > 2 ** AW) begin
            exp_err = 1'b1; exp_done = 1'b0; exp_cnt = 0;
            return;
        end
        for (int k = 0; k < n; k++)
            exp_q.push_back('{addr: k[AW-1:0], op: {stream[2+4*k], stream[3+4*k]},
                              opd: {stream[4+4*k], stream[5+4*k]}});
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) x ^= stream[i];
        exp_done = stream[2+4*n] == x;
        exp_err  = !exp_done;
        exp_cnt  = n;
    endfunction

    task automatic make_stream(int n, bit good);
        logic [7:0] x;
        logic [15:0] nw;
        nw = n[15:0];
        stream.delete();
        stream.push_back(nw[15:8]);
        stream.push_back(nw[7:0]);
        if (n > 2 ** AW) return;
        for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
        x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        stream.push_back(good ? x : x ^ 8'(1 << $urandom_range(7)));
    endtask

    task automatic set_nominal(logic [7:0] chk);
        stream = '{8'h00, 8'h02, 8'h10, 8'h21, 8'h00, 8'h05, 8'h70, 8'h00, 8'h00, 8'h00, chk};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(int lo, int hi, int gap_pct);
        int idx, budget;
        idx = lo;
        budget = 0;
        while (idx < hi) begin
            logic rdy, v;
            rdy = bus.in_ready;
            v = $urandom_range(99) >= gap_pct;
            bus.in_valid = v;
            bus.in_data = v ? stream[idx] : 8'($urandom);
            @(posedge clk); #1;
            if (v && rdy) idx++;
            budget++;
            if (budget > 6000) begin
                check("send_timeout", 64'(idx), 64'(hi));
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic finish_load(string name);
        check({name, "_done"}, done, exp_done);
        check({name, "_error"}, error, exp_err);
        check({name, "_hold"}, cpu_hold, !exp_done);
        check({name, "_count"}, loaded_count, 64'(exp_cnt));
        check({name, "_ready"}, bus.in_ready, 1'b0);
        @(negedge clk);
        check({name, "_pending_writes"}, 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic run_load(string name, int gap, bit do_start);
        log_q.delete();
        model();
        if (do_start) pulse_start();
        send(0, stream.size(), gap);
        finish_load(name);
    endtask

    always @(negedge clk) if (reset) begin
        check("hold_vs_done", cpu_hold, !done);
        if (done || error) check("ready_when_finished", bus.in_ready, 1'b0);
        if (bus.prog_we) begin
            dw = '{addr: bus.prog_addr, op: bus.prog_opcode, opd: bus.prog_operand};
            log_q.push_back(dw);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h expected none", dw);
            end else begin
                cw = exp_q.pop_front();
                check("write", dw, cw);
                check("count_on_write", loaded_count, 64'(cw.addr) + 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", cpu_hold, 1'b1);
        check("rst_ready", bus.in_ready, 1'b0);
        check("rst_we", bus.prog_we, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_count", loaded_count, 0);
        check("rst_addr", bus.prog_addr, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        set_nominal(8'h46);
        run_load("nominal", 0, 1'b1);
        check("nom_log_size", 64'(log_q.size()), 2);
        check("nom_w0", log_q[0], 40'h00_1021_0005);
        check("nom_w1", log_q[1], 40'h01_7000_0000);
        check("nom_done_lit", done, 1'b1);
        check("nom_count_lit", loaded_count, 2);

        set_nominal(8'h47);
        run_load("badchk", 0, 1'b1);
        check("bad_err_lit", error, 1'b1);
        check("bad_writes", 64'(log_q.size()), 2);

        stream = '{8'h00, 8'h00, 8'h00};
        run_load("zero_len", 0, 1'b1);
        check("zero_writes", 64'(log_q.size()), 0);

        stream = '{8'h01, 8'h01};
        run_load("oversize", 0, 1'b1);
        check("over_err_lit", error, 1'b1);

        set_nominal(8'h46);
        run_load("gaps", 50, 1'b1);
        check("gaps_w0", log_q[0], 40'h00_1021_0005);
        check("gaps_w1", log_q[1], 40'h01_7000_0000);

        set_nominal(8'h46);
        log_q.delete();
        model();
        pulse_start();
        send(0, 6, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_hold", cpu_hold, 1'b1);
        check("mid_rst_ready", bus.in_ready, 1'b0);
        check("mid_rst_we", bus.prog_we, 1'b0);
        check("mid_rst_count", loaded_count, 0);
        check("mid_rst_addr", bus.prog_addr, 0);
        check("mid_rst_op", bus.prog_opcode, 0);
        check("mid_rst_opd", bus.prog_operand, 0);
        check("mid_rst_logged", 64'(log_q.size()), 1);
        exp_q.delete();
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        set_nominal(8'h46);
        run_load("after_reset", 0, 1'b1);

        set_nominal(8'h46);
        log_q.delete();
        model();
        pulse_start();
        send(0, 5, 0);
        pulse_start();
        send(5, stream.size(), 0);
        finish_load("start_in_body");

        pulse_start();
        check("rearm_done", done, 1'b0);
        check("rearm_hold", cpu_hold, 1'b1);
        check("rearm_count", loaded_count, 0);
        check("rearm_ready", bus.in_ready, 1'b1);
        make_stream(3, 1'b1);
        run_load("rearm_load", 20, 1'b0);
        check("rearm_first_addr", log_q[0].addr, 0);

        for (int t = 0; t < 10; t++) begin
            int n;
            n = $urandom_range(9) == 0 ? 256 + $urandom_range(2) : $urandom_range(12);
            make_stream(n, $urandom_range(3) != 0);
            run_load("random", $urandom_range(60), 1'b1);
        end

        make_stream(256, 1'b1);
        run_load("max_len", 20, 1'b1);
        check("max_last_addr", log_q[255].addr, 8'hFF);
        check("max_count_lit", loaded_count, 256);

        make_stream(257, 1'b1);
        run_load("max_plus_one", 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
